seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 30 +++
 rtl/hex_to_7seg.sv | 32 +++
 rtl/seven_seg_scanner.sv | 130 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner: active-low gfedcba glyphs,
// the all-off pattern and the scan FSM state encoding.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low gfedcba glyph lookup; zero latency, no flow control.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nibble)
      4'h0: o_seg = GLYPH_0;
      4'h1: o_seg = GLYPH_1;
      4'h2: o_seg = GLYPH_2;
      4'h3: o_seg = GLYPH_3;
      4'h4: o_seg = GLYPH_4;
      4'h5: o_seg = GLYPH_5;
      4'h6: o_seg = GLYPH_6;
      4'h7: o_seg = GLYPH_7;
      4'h8: o_seg = GLYPH_8;
      4'h9: o_seg = GLYPH_9;
      4'hA: o_seg = GLYPH_A;
      4'hB: o_seg = GLYPH_B;
      4'hC: o_seg = GLYPH_C;
      4'hD: o_seg = GLYPH_D;
      4'hE: o_seg = GLYPH_E;
      4'hF: o_seg = GLYPH_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed hex display scanner: one digit per scan_clk rise, blank gap between digits,
// per-frame value latch. SEVEN_SEG_LZ_BLANK_EN enables leading-zero blanking.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNTW = $clog2(BLANK_CYCLES + 1);
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_DIGITS - 1);
  localparam logic [CNTW-1:0] BLANK_LOAD = CNTW'(BLANK_CYCLES - 1);

  logic                    r_sync1, r_sync2, r_hist;
  state_t                  r_state;
  logic [CNTW-1:0]         r_cnt;
  logic [IDXW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;

  logic                    w_tick;
  logic [IDXW-1:0]         w_next_idx;
  logic                    w_latch;
  logic [4*NUM_DIGITS-1:0] w_eff_val;
  logic [NUM_DIGITS-1:0]   w_eff_dp;
  logic [3:0]              w_nib;
  logic [6:0]              w_glyph;
  logic                    w_lz;
  logic [6:0]              w_seg_next;
  logic [NUM_DIGITS-1:0]   w_an_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= scan_clk;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_tick     = r_sync2 & ~r_hist;
  assign w_next_idx = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

  // Entering digit 0 is the frame boundary: decode straight from the live inputs
  // so the first digit of a frame already shows the newly latched data.
  assign w_latch   = (w_next_idx == '0);
  assign w_eff_val = w_latch ? value : r_shadow_val;
  assign w_eff_dp  = w_latch ? dp_in : r_shadow_dp;
  assign w_nib     = w_eff_val[{w_next_idx, 2'b00} +: 4];
  assign w_an_next = ~(NUM_DIGITS'(1) << w_next_idx);

  hex_to_7seg u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_glyph)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [4*NUM_DIGITS-1:0] w_upper;
  assign w_upper = w_eff_val >> {w_next_idx, 2'b00};
  assign w_lz    = (w_next_idx != '0) && (w_upper == '0);
`else
  assign w_lz    = 1'b0;
`endif

  assign w_seg_next = w_lz ? SEG_OFF : w_glyph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= LAST_IDX;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      an           <= '1;
      seg          <= SEG_OFF;
      dp           <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= BLANK;
            r_cnt   <= BLANK_LOAD;
          end
        end
        // Ticks arriving here are deliberately ignored so a fast edge cannot skip a digit.
        BLANK: begin
          if (r_cnt == '0) begin
            r_state <= DRIVE;
            r_idx   <= w_next_idx;
            an      <= w_an_next;
            seg     <= w_seg_next;
            dp      <= ~w_eff_dp[w_next_idx];
            if (w_latch) begin
              r_shadow_val <= value;
              r_shadow_dp  <= dp_in;
              frame_done   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DRIVE: begin
          if (w_tick) begin
            r_state <= BLANK;
            r_cnt   <= BLANK_LOAD;
            an      <= '1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: expected digit drives are queued per tick and
// checked by a monitor whenever the display leaves blanking.
module tb_seven_seg_scanner;

  localparam logic [6:0] G0 = 7'h40;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G2 = 7'h24;
  localparam logic [6:0] G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19;
  localparam logic [6:0] G7 = 7'h78;
  localparam logic [6:0] G8 = 7'h00;
  localparam logic [6:0] GA = 7'h08;
  localparam logic [6:0] GB = 7'h03;
  localparam logic [6:0] GC = 7'h46;
  localparam logic [6:0] GD = 7'h21;
`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam logic [6:0] GLZ = 7'h7F;
`else
  localparam logic [6:0] GLZ = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_clk = 1'b0;
  logic [15:0] value = 16'h1234;
  logic [3:0]  dp_in = 4'b0010;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .BLANK_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_clk   (scan_clk),
    .value      (value),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic [7:0] blank;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         n_vec = 0;
  int         n_bad = 0;
  int         fd_exp = 0;
  int         fd_seen = 0;
  int         blank_run = 0;
  logic [3:0] prev_an = 4'hF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d,
                      input logic f, input int b);
    exp_t t;
    t.an    = a;
    t.seg   = s;
    t.dp    = d;
    t.fd    = f;
    t.blank = 8'(b);
    q.push_back(t);
    if (f) fd_exp++;
  endtask

  // mode 0: plain tick; 1: also check the 3-edge blanking latency; 2: second rise inside BLANK
  task automatic tick(input int mode);
    @(posedge clk); #2 scan_clk = 1'b1;
    if (mode == 1) begin
      repeat (2) @(posedge clk);
      #1 chk("lat_still_driving", {31'd0, an == 4'hF}, 32'd0);
      @(posedge clk);
      #1 chk("lat_blank_at_edge3", {28'd0, an}, 32'hF);
    end else if (mode == 2) begin
      repeat (3) @(posedge clk);
      #2 scan_clk = 1'b0;
      repeat (2) @(posedge clk);
      #2 scan_clk = 1'b1;
      repeat (3) @(posedge clk);
    end else begin
      repeat (3) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    #2 scan_clk = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      blank_run = 0;
      prev_an   = 4'hF;
    end else begin
      if (frame_done) fd_seen++;
      if (an == 4'hF) begin
        blank_run++;
      end else if (prev_an == 4'hF) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_drive: an=%b with nothing expected", an);
        end else begin
          e = q.pop_front();
          chk("an", {28'd0, an}, {28'd0, e.an});
          chk("seg", {25'd0, seg}, {25'd0, e.seg});
          chk("dp", {31'd0, dp}, {31'd0, e.dp});
          chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
          if (e.blank != 0) chk("blank_len", blank_run, {24'd0, e.blank});
        end
        blank_run = 0;
      end
      prev_an = an;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (50) @(posedge clk);
    #1 chk("idle_an", {28'd0, an}, 32'hF);

    // frame 1 and 2 with 1234, dp requested on digit 1
    push(4'b1110, G4, 1'b1, 1'b1, 0);  tick(0);
    push(4'b1101, G3, 1'b0, 1'b0, 16); tick(1);
    push(4'b1011, G2, 1'b1, 1'b0, 16); tick(0);
    push(4'b0111, G1, 1'b1, 1'b0, 16); tick(0);
    push(4'b1110, G4, 1'b1, 1'b1, 16); tick(0);
    push(4'b1101, G3, 1'b0, 1'b0, 16); tick(0);
    push(4'b1011, G2, 1'b1, 1'b0, 16); tick(0);

    // change while digit 2 is on: must not tear the rest of this frame
    value = 16'hABCD;
    dp_in = 4'b1000;
    push(4'b0111, G1, 1'b1, 1'b0, 16); tick(0);
    push(4'b1110, GD, 1'b1, 1'b1, 16); tick(0);
    push(4'b1101, GC, 1'b1, 1'b0, 16); tick(2);
    push(4'b1011, GB, 1'b1, 1'b0, 16); tick(0);

    // scan_clk stuck high then stuck low: digit holds
    push(4'b0111, GA, 1'b0, 1'b0, 16);
    @(posedge clk); #2 scan_clk = 1'b1;
    repeat (300) @(posedge clk);
    #1 chk("stuck_high_an", {28'd0, an}, 32'h7);
    @(posedge clk); #2 scan_clk = 1'b0;
    repeat (300) @(posedge clk);
    #1 chk("stuck_low_an", {28'd0, an}, 32'h7);

    push(4'b1110, GD, 1'b1, 1'b1, 16); tick(0);
    push(4'b1101, GC, 1'b1, 1'b0, 16); tick(0);

    // async reset while digit 1 drives
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_an", {28'd0, an}, 32'hF);
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_dp", {31'd0, dp}, 32'd1);
    value = 16'h5678;
    dp_in = 4'b0000;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    push(4'b1110, G8, 1'b1, 1'b1, 0); tick(0);

    // leading-zero patterns
    @(posedge clk); #2 rst = 1'b1;
    value = 16'h0070;
    dp_in = 4'b0100;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    push(4'b1110, G0,  1'b1, 1'b1, 0);  tick(0);
    push(4'b1101, G7,  1'b1, 1'b0, 16); tick(0);
    push(4'b1011, GLZ, 1'b0, 1'b0, 16); tick(0);
    push(4'b0111, GLZ, 1'b1, 1'b0, 16); tick(0);
    value = 16'h0000;
    dp_in = 4'b0000;
    push(4'b1110, G0,  1'b1, 1'b1, 16); tick(0);
    push(4'b1101, GLZ, 1'b1, 1'b0, 16); tick(0);
    push(4'b1011, GLZ, 1'b1, 1'b0, 16); tick(0);
    push(4'b0111, GLZ, 1'b1, 1'b0, 16); tick(0);

    repeat (20) @(posedge clk);
    #1;
    chk("expected_drives_left", q.size(), 32'd0);
    chk("frame_done_pulses", fd_seen, fd_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
